muldiv_unit: RTL and testbench

- Parametrised, iterative multiply/divide unit for the br32 execute stage; sits beside the combinational alu and takes the same operand buses.
- Computes signed/unsigned low and high products, and quotients/remainders, using radix-2 shift-add and restoring division.
- Fixed latency for every op; valid/ready handshake on the input and output sides; supports pipeline flush.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/muldiv_core.sv | 36 +++
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and decode helpers for the br32 execute-stage arithmetic units.
// The iterative multiply/divide unit uses the opcode enum and the helpers below.
package alu_pkg;

    typedef enum logic [2:0] {
        MUL   = 3'd0,
        MULH  = 3'd1,
        MULHU = 3'd2,
        RSVD  = 3'd3,
        DIV   = 3'd4,
        DIVU  = 3'd5,
        REM   = 3'd6,
        REMU  = 3'd7
    } mdu_op_e;

    function automatic logic is_signed(mdu_op_e op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_div(mdu_op_e op);
        return op[2];
    endfunction

    // True when the result comes from the accumulator half: high product or remainder.
    function automatic logic wants_high(mdu_op_e op);
        return (op == MULH) || (op == MULHU) || (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// acc holds the partial product high half / partial remainder; lo holds multiplier / quotient bits.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] op_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = acc_i + (lo_i[0] ? {1'b0, op_i} : '0);
        shifted = {acc_i[WIDTH-1:0], lo_i[WIDTH-1]};
        diff    = shifted - {1'b0, op_i};
        acc_o   = {1'b0, sum[WIDTH:1]};
        lo_o    = {sum[0], lo_i[WIDTH-1:1]};
        if (is_div_i) begin
            // The remainder stays below the divisor, so the top bit of diff is the borrow.
            if (!diff[WIDTH]) begin
                acc_o = diff;
                lo_o  = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = shifted;
                lo_o  = {lo_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: works on operand magnitudes for WIDTH cycles,
// then applies sign correction and special-case overrides in a single FIX cycle.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  mdu_op_e          opc_i,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] res_o
);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mdu_op_e          opc_q, opc_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             valid_q, valid_d;

    logic [WIDTH:0]     core_acc;
    logic [WIDTH-1:0]   core_lo;
    logic               sgn1, sgn2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   div_word, div_s, fix_res;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .is_div_i (is_div(opc_q)),
        .acc_i    (acc_q),
        .lo_i     (lo_q),
        .op_i     (b_q),
        .acc_o    (core_acc),
        .lo_o     (core_lo)
    );

    assign ready_o = (state_q == IDLE);
    assign valid_o = valid_q;
    assign res_o   = res_q;

    always_comb begin
        sgn1 = is_signed(opc_i) && op1_i[WIDTH-1];
        sgn2 = is_signed(opc_i) && op2_i[WIDTH-1];
        mag1 = sgn1 ? -op1_i : op1_i;
        mag2 = sgn2 ? -op2_i : op2_i;
    end

    // Division by zero needs no override for REM/REMU: the restoring loop leaves the dividend as remainder.
    always_comb begin
        prod     = {acc_q[WIDTH-1:0], lo_q};
        prod_s   = neg_q ? -prod : prod;
        div_word = wants_high(opc_q) ? acc_q[WIDTH-1:0] : lo_q;
        div_s    = neg_q ? -div_word : div_word;
        if (is_div(opc_q)) begin
            fix_res = div_s;
            if (ovf_q) begin
                fix_res = wants_high(opc_q) ? '0 : MIN_VAL;
            end else if ((b_q == '0) && !wants_high(opc_q)) begin
                fix_res = '1;
            end
        end else if (opc_q == RSVD) begin
            fix_res = '0;
        end else begin
            fix_res = wants_high(opc_q) ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opc_d   = opc_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        b_d     = b_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i && !flush_i) begin
                    opc_d   = opc_i;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    lo_d    = is_div(opc_i) ? mag1 : mag2;
                    b_d     = is_div(opc_i) ? mag2 : mag1;
                    neg_d   = (is_div(opc_i) && wants_high(opc_i)) ? sgn1 : (sgn1 ^ sgn2);
                    ovf_d   = is_signed(opc_i) && is_div(opc_i) &&
                              (op1_i == MIN_VAL) && (op2_i == '1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = core_acc;
                lo_d  = core_lo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                res_d   = fix_res;
                state_d = DONE;
            end
            DONE: begin
                // valid_o is a registered output, so it rises one cycle after entering DONE.
                if (valid_q && ready_i) begin
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opc_q   <= MUL;
            acc_q   <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opc_q   <= opc_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, handshake corner cases, and
// randomized ops on WIDTH=32 and WIDTH=8 instances against an arithmetic reference model.
module tb_muldiv_unit;
    import alu_pkg::*;

    typedef struct {
        mdu_op_e     opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_ready;
    logic        flush;
    mdu_op_e     opc;
    logic [31:0] op1;
    logic [31:0] op2;

    logic        ready32, valid32, ready8, valid8;
    logic [31:0] res32;
    logic [7:0]  res8;
    logic        cur_ready, cur_valid;
    logic [31:0] cur_res;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(req_valid && !sel), .ready_o(ready32),
        .opc_i(opc), .op1_i(op1), .op2_i(op2), .flush_i(flush),
        .valid_o(valid32), .ready_i(req_ready && !sel), .res_o(res32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(req_valid && sel), .ready_o(ready8),
        .opc_i(opc), .op1_i(op1[7:0]), .op2_i(op2[7:0]), .flush_i(flush),
        .valid_o(valid8), .ready_i(req_ready && sel), .res_o(res8)
    );

    assign cur_ready = sel ? ready8 : ready32;
    assign cur_valid = sel ? valid8 : valid32;
    assign cur_res   = sel ? {24'h0, res8} : res32;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on sign- or zero-extended operands.
    function automatic logic [31:0] refModel(mdu_op_e op, logic [31:0] a, logic [31:0] b, int w);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned ua = {32'h0, a} & mask;
        longint unsigned ub = {32'h0, b} & mask;
        longint sa = longint'(ua);
        longint sb = longint'(ub);
        longint minv = -(longint'(1) << (w - 1));
        longint unsigned r;
        if (ua[w-1]) sa = sa - (longint'(1) << w);
        if (ub[w-1]) sb = sb - (longint'(1) << w);
        case (op)
            MUL:   r = ua * ub;
            MULH:  r = longint'(sa * sb) >>> w;
            MULHU: r = (ua * ub) >> w;
            DIV:   r = (ub == 0) ? mask : ((sa == minv && sb == -1) ? ua : longint'(sa / sb));
            DIVU:  r = (ub == 0) ? mask : ua / ub;
            REM:   r = (ub == 0) ? ua : ((sa == minv && sb == -1) ? 64'd0 : longint'(sa % sb));
            REMU:  r = (ub == 0) ? ua : ua % ub;
            default: r = 64'd0;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic logic [31:0] pickOperand(int w);
        logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return mask;
            3: return 32'h1 << (w - 1);
            default: return $urandom & mask;
        endcase
    endfunction

    // Full transaction: accept, latency and busy checks, result, optional backpressure, release.
    task automatic applyStimulus(input logic s, input mdu_op_e o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp,
                                 input string name, input int hold);
        int w = s ? 8 : 32;
        int n = 0;
        int edges = 0;
        logic busy_ok = 1'b1;
        logic stable = 1'b1;
        logic [31:0] got;
        @(negedge clk);
        sel = s; opc = o; op1 = a; op2 = b;
        req_ready = (hold == 0);
        while (!cur_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cur_ready) begin
            checkOutput({name, " ready_o before accept"}, 32'(cur_ready), 32'h1);
            return;
        end
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        opc = mdu_op_e'(3'($urandom_range(0, 7)));
        op1 = $urandom;
        op2 = $urandom;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (cur_valid) break;
            if (cur_ready) busy_ok = 1'b0;
        end
        checkOutput({name, " latency"}, 32'(edges), 32'(w + 2));
        checkOutput({name, " ready_o low while busy"}, 32'(busy_ok), 32'h1);
        checkOutput({name, " result"}, cur_res, exp);
        got = cur_res;
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                if (!cur_valid || cur_res !== got) stable = 1'b0;
            end
            checkOutput({name, " stable under backpressure"}, 32'(stable), 32'h1);
            @(negedge clk);
            req_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        req_ready = 1'b0;
        checkOutput({name, " idle after handshake"}, {30'h0, cur_ready, cur_valid}, 32'h2);
    endtask

    task automatic resetMidBusy(input logic s);
        @(negedge clk);
        sel = s; opc = MULHU; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async reset mid-busy", {30'h0, cur_ready, cur_valid}, 32'h2);
        checkOutput("async reset res_o", cur_res, 32'h0);
        #1;
        rst = 1'b0;
    endtask

    task automatic watchNoValid(input string name, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (cur_valid) seen = 1'b1;
        end
        checkOutput(name, 32'(seen), 32'h0);
    endtask

    vec_t vecs[10];

    initial begin
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_ready = 1'b0; flush = 1'b0;
        opc = MUL; op1 = '0; op2 = '0;
        vecs[0] = '{MUL,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7 x -3"};
        vecs[1] = '{MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH min x min"};
        vecs[2] = '{MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "MUL -1 x -1"};
        vecs[3] = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "DIV -7/2"};
        vecs[4] = '{REM,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "REM -7/2"};
        vecs[5] = '{DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, "DIVU big/2"};
        vecs[6] = '{DIVU,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "DIVU 5/0"};
        vecs[7] = '{REMU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "REMU 5/0"};
        vecs[8] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV overflow"};
        vecs[9] = '{REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "REM overflow"};

        repeat (2) @(negedge clk);
        checkOutput("reset state w32", {29'h0, ready32, valid32, |res32}, 32'h4);
        checkOutput("reset state w8", {29'h0, ready8, valid8, |res8}, 32'h4);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, i % 2);
        end
        applyStimulus(1'b0, RSVD, 32'h1234_5678, 32'h9, 32'h0, "reserved opcode", 0);
        applyStimulus(1'b0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU backpressure", 5);

        // Flush ten cycles into a divide: back to idle and no result ever appears.
        @(negedge clk);
        sel = 1'b0; opc = DIV; op1 = 32'd1000; op2 = 32'd7; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush mid-busy -> idle", {30'h0, cur_ready, cur_valid}, 32'h2);
        watchNoValid("flush suppresses valid_o", 45);
        applyStimulus(1'b0, MUL, 32'd3, 32'd4, 32'd12, "MUL 3x4 after flush", 0);

        // flush together with valid_i in IDLE drops the request.
        @(negedge clk);
        opc = MUL; op1 = 32'd5; op2 = 32'd5; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; flush = 1'b0;
        checkOutput("flush drops request", 32'(cur_ready), 32'h1);
        watchNoValid("dropped request never completes", 40);

        for (int s = 0; s < 2; s++) begin
            int w = (s == 1) ? 8 : 32;
            for (int i = 0; i < 1000; i++) begin
                mdu_op_e o = mdu_op_e'(3'($urandom_range(0, 7)));
                logic [31:0] a = pickOperand(w);
                logic [31:0] b = pickOperand(w);
                applyStimulus(s[0], o, a, b, refModel(o, a, b, w),
                              $sformatf("rand w%0d #%0d op%0d a=%h b=%h", w, i, o, a, b),
                              int'($urandom_range(0, 2)));
                if (i == 500) resetMidBusy(s[0]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
